// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, 8N1 by default, even parity with UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK_100MHz,
    input  logic       Reset_n,
    input  logic       Rx,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       FrameError,
    output logic       ParityError,
    output logic       Busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
    logic          parity_bad;
`else
    assign ParityError = 1'b0;
`endif

    // Synchronizer idles high so reset never looks like a start edge
    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            Data       <= '0;
            Valid      <= 1'b0;
            FrameError <= 1'b0;
            Busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            ParityError <= 1'b0;
            parity_bad  <= 1'b0;
`endif
        end else begin
            Valid      <= 1'b0;
            FrameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
            ParityError <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (!rx_sync) begin
                        state   <= START;
                        bit_cnt <= '0;
                        Busy    <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (rx_sync) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer == BIT_LAST) begin
                        timer       <= '0;
                        parity_bad  <= (rx_sync != ^shift);
                        ParityError <= (rx_sync != ^shift);
                        state       <= STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                            if (!parity_bad) begin
                                Data  <= shift;
                                Valid <= 1'b1;
                            end
`else
                            Data  <= shift;
                            Valid <= 1'b1;
`endif
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            FrameError <= 1'b1;
                            state      <= WAIT_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                // A held-low line stays here so a break reports only one error
                WAIT_IDLE: begin
                    timer <= '0;
                    if (rx_sync) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 The block SHALL have port CLK_100MHz, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port Data, output, 8 bits: last received byte.
REQ-006 The block SHALL have port Valid, output, 1 bit: one-cycle pulse when Data is updated.
REQ-007 The block SHALL have port FrameError, output, 1 bit: one-cycle pulse on a low stop bit.
REQ-008 The block SHALL have port ParityError, output, 1 bit: one-cycle pulse on a parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-009 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 The block SHALL pass Rx through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-011 The block SHALL implement states IDLE, START, DATA, PARITY (only with the macro), STOP and WAIT_IDLE.
REQ-012 In IDLE, a synchronized low SHALL move to START and clear the bit counter.
REQ-013 START SHALL count CLKS_PER_BIT/2 cycles (integer divide), then sample: low -> DATA; high -> IDLE as a false start, with no output pulse.
REQ-014 DATA SHALL sample every CLKS_PER_BIT cycles after the start mid-point, 8 samples, LSB first, shifting into an internal register; Data SHALL NOT change during reception.
REQ-015 After the 8th bit, the block SHALL go to PARITY (macro defined) or STOP; each takes one sample CLKS_PER_BIT cycles after the previous one.
REQ-016 On a high stop sample, the block SHALL copy the shift register to Data and pulse Valid high for exactly one cycle, starting on the cycle after the sample; it SHALL then return to IDLE.
REQ-017 On a low stop sample, the block SHALL pulse FrameError for one cycle, leave Data unchanged, leave Valid low, and enter WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL hold until the synchronized Rx is high, then go to IDLE; a break condition (line held low) SHALL produce exactly one FrameError.
REQ-019 The bit timer SHALL be $clog2(CLKS_PER_BIT) bits wide, reload to 0 at each sample point, and never wrap within a bit.
REQ-020 A start edge arriving in the same cycle as the return to IDLE SHALL be detected on the next cycle, with no frame lost.
REQ-021 Data SHALL hold its value until the next Valid.

Reset
REQ-022 Asserting Reset_n low SHALL immediately force: Data=0x00, Valid=0, FrameError=0, ParityError=0, Busy=0, state=IDLE, counters=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame without any pulse; after release, the first falling edge SHALL start a fresh frame.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: the frame SHALL include one even-parity bit after data; on mismatch, the block SHALL pulse ParityError, suppress Valid, leave Data unchanged, and still check the stop bit.
REQ-025 Macro UART_RX_PARITY_EN undefined: the frame SHALL be 8N1, with no PARITY state, and ParityError SHALL be constant 0.

Verification (CLKS_PER_BIT=16)
REQ-026 Scenario: frame 0xA5 (8N1) -> one Valid pulse 1 cycle after the stop mid-sample, Data=0xA5, no error pulses.
REQ-027 Scenario: Rx low for 4 cycles then high -> no Valid or FrameError; Busy returns to 0 within 10 cycles.
REQ-028 Scenario: byte 0x3C with stop bit low, then line held low for 50 bit times -> exactly one FrameError, no Valid, Data unchanged, Busy high until Rx goes high.
REQ-029 Scenario: back-to-back 0x00 then 0xFF with no idle gap -> two Valid pulses, with Data=0x00 then Data=0xFF.
REQ-030 Scenario: Reset_n pulsed low during bit 4 of 0x5A -> all outputs 0 immediately; a following 0x81 frame is received correctly.
REQ-031 Scenario (with UART_RX_PARITY_EN): byte 0x01 with parity bit 0 -> ParityError pulse, no Valid; byte 0x01 with parity bit 1 -> Valid, Data=0x01.
